ram_sdp_ctrl: RTL and testbench
===============================

RAM_SDP_CTRL -- requirements
Module: ram_sdp_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, address width.
REQ-002 SHALL have parameter DATA_W, default 8, data width; must be an integer multiple of BYTE_W.
REQ-003 SHALL have parameter BYTE_W, default 8, byte-enable granularity; NB = DATA_W/BYTE_W lanes.
REQ-004 SHALL have parameter SIZE, default 2**ADDR_W, word count; legal range 1..2**ADDR_W.
REQ-005 SHALL have parameter RDW_MODE, default 0, same-address read-during-write behaviour: 0 = old data, 1 = new data.
REQ-006 SHALL have parameter OUT_REG, default 0, adds one output register stage when 1.
REQ-007 SHALL have parameter CLEAR_ON_RESET, default 1, starts a zero-fill after reset release when 1.
REQ-008 SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; nrst input 1, asynchronous active-low reset.
REQ-009 SHALL have port ram_write, input, 1 bit: write strobe.
REQ-010 SHALL have port ram_be, input, NB bits: per-lane write enable.
REQ-011 SHALL have port ram_addr_write, input, ADDR_W bits: write address.
REQ-012 SHALL have port ram_data_write, input, DATA_W bits: write data.
REQ-013 SHALL have port ram_read, input, 1 bit: read strobe.
REQ-014 SHALL have port ram_addr_read, input, ADDR_W bits: read address.
REQ-015 SHALL have port ram_data_read, output, DATA_W bits: registered read data.
REQ-016 SHALL have port ram_rvalid, output, 1 bit: one-cycle pulse qualifying ram_data_read.
REQ-017 SHALL have port clear_req, input, 1 bit: request a full zero-fill.
REQ-018 SHALL have port ready, output, 1 bit: high when user accesses are accepted.

Function
REQ-019 Writes SHALL update only lanes with ram_be[i]=1 when ram_write=1 and ready=1; each lane is bits i*BYTE_W +: BYTE_W.
REQ-020 Read latency SHALL be 1 cycle from an accepted ram_read when OUT_REG=0, and 2 cycles when OUT_REG=1; ram_rvalid SHALL pulse in the cycle the data is presented.
REQ-021 ram_data_read SHALL hold its last value when ram_rvalid=0.
REQ-022 Back-to-back reads SHALL be accepted every cycle, giving full throughput.
REQ-023 For a same-cycle read and write to the same address with RDW_MODE=0, the read SHALL return the pre-write word.
REQ-024 For a same-cycle read and write to the same address with RDW_MODE=1, the read SHALL return the word with enabled lanes replaced by ram_data_write and other lanes unchanged.
REQ-025 A write to an address >= SIZE SHALL be discarded; a read from an address >= SIZE SHALL return 0 with ram_rvalid=1.
REQ-026 The clear FSM SHALL have states IDLE and CLEAR.
REQ-027 The FSM SHALL go IDLE->CLEAR on clear_req=1, and CLEAR->IDLE after the write of address SIZE-1.
REQ-028 In CLEAR, an internal counter SHALL write all-zero to addresses 0,1,...,SIZE-1, one per cycle; CLEAR lasts exactly SIZE cycles.
REQ-029 ready SHALL be 1 only in IDLE.
REQ-030 In CLEAR, user reads and writes SHALL be ignored and SHALL NOT produce ram_rvalid.
REQ-031 clear_req asserted during CLEAR SHALL be ignored; the clear SHALL NOT restart.
REQ-032 A read accepted in the cycle before entering CLEAR SHALL still complete with its pre-clear data.
REQ-033 The address counter SHALL be ADDR_W bits wide and SHALL NOT wrap past SIZE-1.

Reset
REQ-034 While nrst=0: FSM=IDLE, counter=0, ram_data_read=0, ram_rvalid=0, pipeline valid bits=0, ready=0.
REQ-035 After nrst rises with CLEAR_ON_RESET=1, the FSM SHALL enter CLEAR on the first clock edge; with CLEAR_ON_RESET=0 it SHALL enter IDLE with ready=1.
REQ-036 Reset SHALL NOT itself modify memory contents.
REQ-037 Reset asserted mid-CLEAR SHALL abort the clear; with CLEAR_ON_RESET=1 the clear SHALL restart from address 0 after release.

Verification
REQ-038 Bench SHALL cover post-reset clear with SIZE=16, CLEAR_ON_RESET=1: ready=0 for 16 cycles then 1; reads of addresses 0..15 return 0.
REQ-039 Bench SHALL cover byte enables with DATA_W=32: write 0xAABBCCDD, be=4'b1111, then 0x11223344, be=4'b0101, to address 3; a read returns 0xAA22CC44 after 1 cycle (OUT_REG=0) or 2 cycles (OUT_REG=1).
REQ-040 Bench SHALL cover read-during-write: address 5 holds 0x12; same-cycle read and write of 0x34 to address 5 returns 0x12 (RDW_MODE=0) or 0x34 (RDW_MODE=1); the next read returns 0x34.
REQ-041 Bench SHALL cover out of range with SIZE=10, ADDR_W=4: a write to address 12 is discarded; a read of address 12 returns 0 with ram_rvalid=1; address 9 is unaffected.
REQ-042 Bench SHALL cover user access during clear: clear_req, then a write to address 2 and a read during CLEAR, give no rvalid; memory at address 2 is 0 after clear.
REQ-043 Bench SHALL cover reset at clear cycle 7 of 16: after release, ready stays 0 for a further 16 cycles; all words read back 0.

Source files
------------

// File: rtl/ram_sdp_ctrl.sv
// Simple dual-port RAM with per-lane write enables, selectable read-during-write behaviour,
// optional output register and a sequenced zero-fill that blocks user access while it runs.
module ram_sdp_ctrl #(
  parameter int unsigned ADDR_W         = 8,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned BYTE_W         = 8,
  parameter int unsigned SIZE           = 2 ** ADDR_W,
  parameter int unsigned RDW_MODE       = 0,
  parameter int unsigned OUT_REG        = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                       clk,
  input  logic                       nrst,
  input  logic                       ram_write,
  input  logic [DATA_W/BYTE_W-1:0]   ram_be,
  input  logic [ADDR_W-1:0]          ram_addr_write,
  input  logic [DATA_W-1:0]          ram_data_write,
  input  logic                       ram_read,
  input  logic [ADDR_W-1:0]          ram_addr_read,
  output logic [DATA_W-1:0]          ram_data_read,
  output logic                       ram_rvalid,
  input  logic                       clear_req,
  output logic                       ready
);

  localparam int unsigned NB  = DATA_W / BYTE_W;
  localparam int unsigned AW1 = ADDR_W + 1;
  localparam logic [AW1-1:0]    SizeW    = AW1'(SIZE);
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(SIZE - 1);

  typedef enum logic {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic              started_q, started_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              rvalid1_q, rvalid1_d;

  logic [DATA_W-1:0] mem_q [SIZE];

  logic              wr_in_range, rd_in_range, wr_acc, rd_acc;
  logic [NB-1:0]     mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] rd_word;

  // started_q keeps ready low until the first edge after reset release.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    started_d = 1'b1;
    case (state_q)
      StIdle: begin
        if (!started_q) begin
          if (CLEAR_ON_RESET != 0) state_d = StClear;
        end else if (clear_req) begin
          state_d = StClear;
        end
      end
      StClear: begin
        if (cnt_q == LastAddr) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign ready       = started_q && (state_q == StIdle);
  assign wr_in_range = {1'b0, ram_addr_write} < SizeW;
  assign rd_in_range = {1'b0, ram_addr_read} < SizeW;
  assign wr_acc      = ready && ram_write && wr_in_range;
  assign rd_acc      = ready && ram_read;

  always_comb begin
    mem_we    = '0;
    mem_waddr = ram_addr_write;
    mem_wdata = ram_data_write;
    if (state_q == StClear) begin
      mem_we    = '1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (wr_acc) begin
      mem_we = ram_be;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < NB; i++) begin
      if (mem_we[i]) mem_q[mem_waddr][i*BYTE_W +: BYTE_W] <= mem_wdata[i*BYTE_W +: BYTE_W];
    end
  end

  // Out-of-range reads return zero; new-data mode forwards the enabled write lanes.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem_q[ram_addr_read];
      if ((RDW_MODE != 0) && wr_acc && (ram_addr_write == ram_addr_read)) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (ram_be[i]) rd_word[i*BYTE_W +: BYTE_W] = ram_data_write[i*BYTE_W +: BYTE_W];
        end
      end
    end
  end

  always_comb begin
    rvalid1_d = rd_acc;
    rdata1_d  = rd_acc ? rd_word : rdata1_q;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StIdle;
      started_q <= 1'b0;
      cnt_q     <= '0;
      rdata1_q  <= '0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      started_q <= started_d;
      cnt_q     <= cnt_d;
      rdata1_q  <= rdata1_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_W-1:0] rdata2_q, rdata2_d;
    logic              rvalid2_q, rvalid2_d;

    always_comb begin
      rvalid2_d = rvalid1_q;
      rdata2_d  = rvalid1_q ? rdata1_q : rdata2_q;
    end

    always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
        rdata2_q  <= '0;
        rvalid2_q <= 1'b0;
      end else begin
        rdata2_q  <= rdata2_d;
        rvalid2_q <= rvalid2_d;
      end
    end

    assign ram_data_read = rdata2_q;
    assign ram_rvalid    = rvalid2_q;
  end else begin : g_no_out_reg
    assign ram_data_read = rdata1_q;
    assign ram_rvalid    = rvalid1_q;
  end

endmodule

// File: tb/tb_ram_sdp_ctrl.sv
// Directed bench: two instances share stimulus. A = SIZE 16, old-data RDW, no output reg;
// B = SIZE 10, new-data RDW, output reg (2-cycle latency).
module tb_ram_sdp_ctrl;

  logic        clk = 1'b0;
  logic        nrst;
  logic        ram_write, ram_read, clear_req;
  logic [3:0]  ram_be, waddr, raddr;
  logic [31:0] wdata;
  logic [31:0] a_rdata, b_rdata;
  logic        a_rvalid, b_rvalid, a_ready, b_ready;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ram_sdp_ctrl #(
    .ADDR_W(4), .DATA_W(32), .BYTE_W(8), .SIZE(16),
    .RDW_MODE(0), .OUT_REG(0), .CLEAR_ON_RESET(1)
  ) u_a (
    .clk(clk), .nrst(nrst), .ram_write(ram_write), .ram_be(ram_be),
    .ram_addr_write(waddr), .ram_data_write(wdata), .ram_read(ram_read),
    .ram_addr_read(raddr), .ram_data_read(a_rdata), .ram_rvalid(a_rvalid),
    .clear_req(clear_req), .ready(a_ready)
  );

  ram_sdp_ctrl #(
    .ADDR_W(4), .DATA_W(32), .BYTE_W(8), .SIZE(10),
    .RDW_MODE(1), .OUT_REG(1), .CLEAR_ON_RESET(1)
  ) u_b (
    .clk(clk), .nrst(nrst), .ram_write(ram_write), .ram_be(ram_be),
    .ram_addr_write(waddr), .ram_data_write(wdata), .ram_read(ram_read),
    .ram_addr_read(raddr), .ram_data_read(b_rdata), .ram_rvalid(b_rvalid),
    .clear_req(clear_req), .ready(b_ready)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    ram_write = 1'b1; waddr = a; wdata = d; ram_be = be;
    tick();
    ram_write = 1'b0;
  endtask

  task automatic test_reset();
    logic ea, eb;
    nrst = 1'b0;
    #1;
    repeat (2) tick();
    n_vec++; if (a_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_a got %b want 0", a_ready); end
    n_vec++; if (b_ready !== 1'b0) begin n_err++; $display("FAIL rst_ready_b got %b want 0", b_ready); end
    n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid_a got %b want 0", a_rvalid); end
    n_vec++; if (b_rdata !== 32'h0) begin n_err++; $display("FAIL rst_data_b got %h want 0", b_rdata); end
    nrst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      ea = (k >= 17); eb = (k >= 11);
      n_vec++; if (a_ready !== ea) begin n_err++; $display("FAIL post_rst_ready_a k=%0d got %b want %b", k, a_ready, ea); end
      n_vec++; if (b_ready !== eb) begin n_err++; $display("FAIL post_rst_ready_b k=%0d got %b want %b", k, b_ready, eb); end
    end
    for (int i = 0; i < 16; i++) begin
      ram_read = 1'b1; raddr = 4'(i);
      tick();
      ram_read = 1'b0;
      n_vec++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin n_err++; $display("FAIL clr_read_a @%0d got %b/%h want 1/0", i, a_rvalid, a_rdata); end
      tick();
      n_vec++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h0) begin n_err++; $display("FAIL clr_read_b @%0d got %b/%h want 1/0", i, b_rvalid, b_rdata); end
    end
  endtask

  task automatic test_byte_enable();
    wr(4'd3, 32'hAABBCCDD, 4'hF);
    wr(4'd3, 32'h11223344, 4'h5);
    ram_read = 1'b1; raddr = 4'd3;
    tick();
    ram_read = 1'b0;
    n_vec++; if (a_rvalid !== 1'b1) begin n_err++; $display("FAIL be_rvalid_a got %b want 1", a_rvalid); end
    n_vec++; if (a_rdata !== 32'hAA22CC44) begin n_err++; $display("FAIL be_data_a got %h want aa22cc44", a_rdata); end
    n_vec++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL be_early_b got %b want 0", b_rvalid); end
    tick();
    n_vec++; if (b_rvalid !== 1'b1) begin n_err++; $display("FAIL be_rvalid_b got %b want 1", b_rvalid); end
    n_vec++; if (b_rdata !== 32'hAA22CC44) begin n_err++; $display("FAIL be_data_b got %h want aa22cc44", b_rdata); end
    n_vec++; if (a_rvalid !== 1'b0) begin n_err++; $display("FAIL be_pulse_a got %b want 0", a_rvalid); end
    n_vec++; if (a_rdata !== 32'hAA22CC44) begin n_err++; $display("FAIL be_hold_a got %h want aa22cc44", a_rdata); end
  endtask

  task automatic test_rdw();
    logic [3:0]  t_addr [2] = '{4'd5, 4'd6};
    logic [31:0] t_wd   [2] = '{32'h34, 32'h11223344};
    logic [3:0]  t_be   [2] = '{4'hF, 4'h5};
    logic [31:0] t_ea   [2] = '{32'h12, 32'hAABBCCDD};
    logic [31:0] t_eb   [2] = '{32'h34, 32'hAA22CC44};
    wr(4'd5, 32'h12, 4'hF);
    wr(4'd6, 32'hAABBCCDD, 4'hF);
    for (int v = 0; v < 2; v++) begin
      ram_write = 1'b1; waddr = t_addr[v]; wdata = t_wd[v]; ram_be = t_be[v];
      ram_read = 1'b1; raddr = t_addr[v];
      tick();
      ram_write = 1'b0; ram_read = 1'b0;
      n_vec++; if (a_rvalid !== 1'b1 || a_rdata !== t_ea[v]) begin n_err++; $display("FAIL rdw_a v%0d got %b/%h want 1/%h", v, a_rvalid, a_rdata, t_ea[v]); end
      tick();
      n_vec++; if (b_rvalid !== 1'b1 || b_rdata !== t_eb[v]) begin n_err++; $display("FAIL rdw_b v%0d got %b/%h want 1/%h", v, b_rvalid, b_rdata, t_eb[v]); end
    end
    for (int v = 0; v < 2; v++) begin
      ram_read = 1'b1; raddr = t_addr[v];
      tick();
      ram_read = 1'b0;
      n_vec++; if (a_rdata !== t_eb[v]) begin n_err++; $display("FAIL rdw_after_a v%0d got %h want %h", v, a_rdata, t_eb[v]); end
      tick();
      n_vec++; if (b_rdata !== t_eb[v]) begin n_err++; $display("FAIL rdw_after_b v%0d got %h want %h", v, b_rdata, t_eb[v]); end
    end
  endtask

  task automatic test_out_of_range();
    logic [3:0]  t_addr [2] = '{4'd12, 4'd9};
    logic [31:0] t_ea   [2] = '{32'hDEAD, 32'h99};
    logic [31:0] t_eb   [2] = '{32'h0, 32'h99};
    wr(4'd9, 32'h99, 4'hF);
    wr(4'd12, 32'hDEAD, 4'hF);
    for (int v = 0; v < 2; v++) begin
      ram_read = 1'b1; raddr = t_addr[v];
      tick();
      ram_read = 1'b0;
      n_vec++; if (a_rvalid !== 1'b1 || a_rdata !== t_ea[v]) begin n_err++; $display("FAIL oor_a @%0d got %b/%h want 1/%h", t_addr[v], a_rvalid, a_rdata, t_ea[v]); end
      tick();
      n_vec++; if (b_rvalid !== 1'b1 || b_rdata !== t_eb[v]) begin n_err++; $display("FAIL oor_b @%0d got %b/%h want 1/%h", t_addr[v], b_rvalid, b_rdata, t_eb[v]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  t_addr [3] = '{4'd3, 4'd5, 4'd9};
    logic [31:0] t_exp  [3] = '{32'hAA22CC44, 32'h34, 32'h99};
    for (int k = 0; k < 4; k++) begin
      ram_read = (k < 3);
      if (k < 3) raddr = t_addr[k];
      tick();
      if (k < 3) begin
        n_vec++; if (a_rvalid !== 1'b1 || a_rdata !== t_exp[k]) begin n_err++; $display("FAIL b2b_a k=%0d got %b/%h want 1/%h", k, a_rvalid, a_rdata, t_exp[k]); end
      end else begin
        n_vec++; if (a_rvalid !== 1'b0 || a_rdata !== t_exp[2]) begin n_err++; $display("FAIL b2b_a_end got %b/%h want 0/%h", a_rvalid, a_rdata, t_exp[2]); end
      end
      if (k >= 1) begin
        n_vec++; if (b_rvalid !== 1'b1 || b_rdata !== t_exp[k-1]) begin n_err++; $display("FAIL b2b_b k=%0d got %b/%h want 1/%h", k, b_rvalid, b_rdata, t_exp[k-1]); end
      end else begin
        n_vec++; if (b_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_b_first got %b want 0", b_rvalid); end
      end
    end
    ram_read = 1'b0;
  endtask

  task automatic test_clear_access();
    logic ea, eb, va, vb;
    wr(4'd2, 32'h77, 4'hF);
    // The read issued alongside clear_req is accepted and must finish with pre-clear data.
    clear_req = 1'b1; ram_read = 1'b1; raddr = 4'd5;
    for (int k = 1; k <= 17; k++) begin
      tick();
      ea = (k >= 17); eb = (k >= 11); va = (k == 1); vb = (k == 2);
      n_vec++; if (a_ready !== ea) begin n_err++; $display("FAIL clr_ready_a k=%0d got %b want %b", k, a_ready, ea); end
      n_vec++; if (b_ready !== eb) begin n_err++; $display("FAIL clr_ready_b k=%0d got %b want %b", k, b_ready, eb); end
      n_vec++; if (a_rvalid !== va) begin n_err++; $display("FAIL clr_rvalid_a k=%0d got %b want %b", k, a_rvalid, va); end
      n_vec++; if (b_rvalid !== vb) begin n_err++; $display("FAIL clr_rvalid_b k=%0d got %b want %b", k, b_rvalid, vb); end
      if (k == 1) begin
        n_vec++; if (a_rdata !== 32'h34) begin n_err++; $display("FAIL preclr_data_a got %h want 34", a_rdata); end
        ram_write = 1'b1; waddr = 4'd2; wdata = 32'h55; ram_be = 4'hF; raddr = 4'd2;
      end
      if (k == 2) begin
        n_vec++; if (b_rdata !== 32'h34) begin n_err++; $display("FAIL preclr_data_b got %h want 34", b_rdata); end
      end
      if (k == 3) begin
        clear_req = 1'b0; ram_write = 1'b0; ram_read = 1'b0;
      end
    end
    for (int v = 0; v < 2; v++) begin
      ram_read = 1'b1; raddr = (v == 0) ? 4'd2 : 4'd5;
      tick();
      ram_read = 1'b0;
      n_vec++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin n_err++; $display("FAIL after_clr_a @%0d got %b/%h want 1/0", raddr, a_rvalid, a_rdata); end
      tick();
      n_vec++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h0) begin n_err++; $display("FAIL after_clr_b @%0d got %b/%h want 1/0", raddr, b_rvalid, b_rdata); end
    end
  endtask

  task automatic test_reset_mid_clear();
    logic ea, eb;
    for (int i = 0; i < 16; i++) wr(4'(i), 32'hA0 + 32'(i), 4'hF);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    repeat (6) tick();
    nrst = 1'b0;
    #1;
    n_vec++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %b%b want 00", a_ready, b_ready); end
    n_vec++; if (a_rdata !== 32'h0 || b_rdata !== 32'h0) begin n_err++; $display("FAIL midrst_data got %h/%h want 0/0", a_rdata, b_rdata); end
    repeat (2) tick();
    nrst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      ea = (k >= 17); eb = (k >= 11);
      n_vec++; if (a_ready !== ea) begin n_err++; $display("FAIL midrst_ready_a k=%0d got %b want %b", k, a_ready, ea); end
      n_vec++; if (b_ready !== eb) begin n_err++; $display("FAIL midrst_ready_b k=%0d got %b want %b", k, b_ready, eb); end
    end
    for (int i = 0; i < 16; i++) begin
      ram_read = 1'b1; raddr = 4'(i);
      tick();
      ram_read = 1'b0;
      n_vec++; if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin n_err++; $display("FAIL midrst_read_a @%0d got %b/%h want 1/0", i, a_rvalid, a_rdata); end
      tick();
      n_vec++; if (b_rvalid !== 1'b1 || b_rdata !== 32'h0) begin n_err++; $display("FAIL midrst_read_b @%0d got %b/%h want 1/0", i, b_rvalid, b_rdata); end
    end
  endtask

  initial begin
    nrst = 1'b0; ram_write = 1'b0; ram_read = 1'b0; clear_req = 1'b0;
    ram_be = 4'h0; waddr = 4'h0; raddr = 4'h0; wdata = 32'h0;
    test_reset();
    test_byte_enable();
    test_rdw();
    test_out_of_range();
    test_back_to_back();
    test_clear_access();
    test_reset_mid_clear();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached at %0t", $time);
    $fatal(1);
  end

endmodule
